// File: rtl/hrm_mem_arbiter_pkg.sv
// hrm_pkg: shared definitions for the data-RAM arbiter slice.
//   AW_DEF / DW_DEF  default address / data widths of the CPU data RAM
//   STARVE_DEF       default debug wait limit before a forced CPU stall
//   WCNT_W           width of the debug wait counter (limit range 0..255)
//   IDLE / ACK       state encoding of the arbiter FSM, wrapped in state_t
package hrm_pkg;

  localparam int AW_DEF     = 8;
  localparam int DW_DEF     = 8;
  localparam int STARVE_DEF = 15;
  localparam int WCNT_W     = 8;

  localparam logic IDLE = 1'b0;
  localparam logic ACK  = 1'b1;

  typedef enum logic {
    ST_IDLE = IDLE,
    ST_ACK  = ACK
  } state_t;

endpackage

// File: rtl/hrm_mem_arbiter_if.sv
// hrm_mem_arbiter_if: bundle of the three sides of the shared data RAM.
//   cpu_*  CPU datapath request (req/we/addr/wdata in, rdata/stall out)
//   dbg_*  debug/monitor host request (req/we/addr/wdata in, ack/rdata out)
//   mem_*  single-port synchronous RAM (addr/we/wdata out, rdata in)
// Modports:
//   slave  - the arbiter's view (consumes requests, drives the RAM)
//   master - the surrounding system's view (CPU, debug host and RAM)
interface hrm_mem_arbiter_if
  import hrm_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;

  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_ack;
  logic [DW-1:0] dbg_rdata;

  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_stall,
    output dbg_ack, dbg_rdata,
    output mem_addr, mem_we, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_stall,
    input  dbg_ack, dbg_rdata,
    input  mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/hrm_mem_arbiter.sv
// hrm_mem_arbiter: shares the CPU's single-port synchronous data RAM with a
// debug/monitor host. The CPU owns the port with no added latency; the
// debugger takes idle cycles, and after STARVE refused cycles it is granted
// anyway, which stalls the CPU for exactly one cycle.
// Ports:
//   clk    clock
//   i_rst  synchronous active-high reset
//   bus    hrm_mem_arbiter_if.slave (cpu_*, dbg_*, mem_* groups)
// Parameters:
//   AW, DW  address / data width
//   STARVE  refused-cycle limit for a pending debug request, 0..255
module hrm_mem_arbiter
  import hrm_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int STARVE = STARVE_DEF
) (
  input  logic             clk,
  input  logic             i_rst,
  hrm_mem_arbiter_if.slave bus
);

  localparam logic [WCNT_W-1:0] STARVE_LIM = WCNT_W'(STARVE);
  localparam logic [WCNT_W-1:0] CNT_ONE    = WCNT_W'(1);

  state_t              state_reg;
  logic [WCNT_W-1:0]   wait_cnt_reg;
  logic                dbg_ack_reg;
  logic                dbg_we_reg;
  logic [DW-1:0]       dbg_rdata_reg;
  logic                cpu_rd_d_reg;
  logic [DW-1:0]       cpu_hold_reg;

  logic                starve_hit;
  logic                dbg_grant;
  logic [AW-1:0]       mem_addr_mux;
  logic [DW-1:0]       mem_wdata_mux;
  logic                mem_we_mux;

  assign starve_hit = (wait_cnt_reg == STARVE_LIM);

  // Reset masks the grant so that during reset the RAM port simply follows
  // the CPU and no debug write can slip into the RAM.
  assign dbg_grant = (state_reg == ST_IDLE) & ~i_rst & bus.dbg_req &
                     (~bus.cpu_req | starve_hit);

  always_comb begin
    mem_addr_mux  = bus.cpu_addr;
    mem_wdata_mux = bus.cpu_wdata;
    mem_we_mux    = bus.cpu_req & bus.cpu_we;
    if (dbg_grant) begin
      mem_addr_mux  = bus.dbg_addr;
      mem_wdata_mux = bus.dbg_wdata;
      mem_we_mux    = bus.dbg_we;
    end
  end

  assign bus.mem_addr  = mem_addr_mux;
  assign bus.mem_wdata = mem_wdata_mux;
  assign bus.mem_we    = mem_we_mux;

  // A grant while the CPU is also asking means the CPU's access was not
  // performed; it must hold state and re-present the same request.
  assign bus.cpu_stall = dbg_grant & bus.cpu_req;

  // The RAM output belongs to the CPU only in the cycle after a CPU read;
  // otherwise show the last CPU read result so a stall or a debug read
  // does not disturb what the CPU is consuming.
  assign bus.cpu_rdata = cpu_rd_d_reg ? bus.mem_rdata : cpu_hold_reg;

  assign bus.dbg_ack   = dbg_ack_reg;
  assign bus.dbg_rdata = dbg_rdata_reg;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_reg     <= ST_IDLE;
      wait_cnt_reg  <= '0;
      dbg_ack_reg   <= 1'b0;
      dbg_we_reg    <= 1'b0;
      dbg_rdata_reg <= '0;
      cpu_rd_d_reg  <= 1'b0;
      cpu_hold_reg  <= '0;
    end else begin
      cpu_rd_d_reg <= bus.cpu_req & ~bus.cpu_we & ~dbg_grant;
      if (cpu_rd_d_reg) begin
        cpu_hold_reg <= bus.mem_rdata;
      end

      case (state_reg)
        ST_IDLE: begin
          if (dbg_grant) begin
            state_reg    <= ST_ACK;
            dbg_ack_reg  <= 1'b1;
            dbg_we_reg   <= bus.dbg_we;
            wait_cnt_reg <= '0;
          end else if (bus.dbg_req & bus.cpu_req & ~starve_hit) begin
            wait_cnt_reg <= wait_cnt_reg + CNT_ONE;
          end
        end
        ST_ACK: begin
          // RAM output now carries the word addressed in the grant cycle.
          state_reg   <= ST_IDLE;
          dbg_ack_reg <= 1'b0;
          if (!dbg_we_reg) begin
            dbg_rdata_reg <= bus.mem_rdata;
          end
        end
        default: begin
          state_reg   <= ST_IDLE;
          dbg_ack_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hrm_mem_arbiter.sv
// tb_hrm_mem_arbiter: two arbiters (STARVE=3 and STARVE=0), each with its own
// RAM, driven by directed vectors and checked every cycle against a
// behavioural model that tracks RAM contents and the grant rules.
module tb_hrm_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic i_rst;

  // Stimulus per instance
  logic       c_req [2];
  logic       c_we  [2];
  logic [7:0] c_addr[2];
  logic [7:0] c_wd  [2];
  logic       d_req [2];
  logic       d_we  [2];
  logic [7:0] d_addr[2];
  logic [7:0] d_wd  [2];

  // Observed outputs per instance
  logic       o_ack  [2];
  logic       o_stall[2];
  logic [7:0] o_crd  [2];
  logic [7:0] o_drd  [2];
  logic [7:0] o_maddr[2];
  logic       o_mwe  [2];
  logic [7:0] o_mwd  [2];

  // RAM behind each arbiter
  logic [7:0] ram [2][256];
  logic [7:0] rd  [2];

  hrm_mem_arbiter_if #(.AW(8), .DW(8)) bi [2] ();

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    hrm_mem_arbiter #(.AW(8), .DW(8), .STARVE(gi == 0 ? 3 : 0)) u_dut (
      .clk   (clk),
      .i_rst (i_rst),
      .bus   (bi[gi])
    );
    assign bi[gi].cpu_req   = c_req[gi];
    assign bi[gi].cpu_we    = c_we[gi];
    assign bi[gi].cpu_addr  = c_addr[gi];
    assign bi[gi].cpu_wdata = c_wd[gi];
    assign bi[gi].dbg_req   = d_req[gi];
    assign bi[gi].dbg_we    = d_we[gi];
    assign bi[gi].dbg_addr  = d_addr[gi];
    assign bi[gi].dbg_wdata = d_wd[gi];
    assign bi[gi].mem_rdata = rd[gi];
    assign o_ack[gi]   = bi[gi].dbg_ack;
    assign o_stall[gi] = bi[gi].cpu_stall;
    assign o_crd[gi]   = bi[gi].cpu_rdata;
    assign o_drd[gi]   = bi[gi].dbg_rdata;
    assign o_maddr[gi] = bi[gi].mem_addr;
    assign o_mwe[gi]   = bi[gi].mem_we;
    assign o_mwd[gi]   = bi[gi].mem_wdata;

    always @(posedge clk) begin
      if (bi[gi].mem_we) ram[gi][bi[gi].mem_addr] <= bi[gi].mem_wdata;
      rd[gi] <= ram[gi][bi[gi].mem_addr];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s u%0d t=%0t got=%0h want=%0h", nm, k, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] mram [2][256];  // what the RAM must contain
  bit         m_ack [2];      // debug access completing this cycle
  int         m_wcnt[2];      // refused cycles of the pending debug request
  logic [7:0] m_cpu [2];      // value of the last completed CPU read
  logic [7:0] m_dbg [2];      // value of the last completed debug read
  bit         m_pwe [2];      // granted debug access was a write
  logic [7:0] m_pval[2];      // RAM word seen by the granted debug access

  function automatic int starve_of(input int k);
    return (k == 0) ? 3 : 0;
  endfunction

  function automatic bit grant_m(input int k);
    return !i_rst && !m_ack[k] && d_req[k] && (!c_req[k] || m_wcnt[k] >= starve_of(k));
  endfunction

  task automatic model_step(input int k);
    bit g;
    g = grant_m(k);
    if (i_rst) begin
      m_ack[k] = 0; m_wcnt[k] = 0; m_cpu[k] = 8'h00; m_dbg[k] = 8'h00;
    end else begin
      if (m_ack[k] && !m_pwe[k]) m_dbg[k] = m_pval[k];
      if (!g && c_req[k] && !c_we[k]) m_cpu[k] = mram[k][c_addr[k]];
      if (g) begin
        m_pwe[k] = d_we[k]; m_pval[k] = mram[k][d_addr[k]]; m_wcnt[k] = 0;
      end else if (!m_ack[k] && d_req[k] && c_req[k] && m_wcnt[k] < starve_of(k)) begin
        m_wcnt[k]++;
      end
      m_ack[k] = g;
    end
    if (g && d_we[k]) mram[k][d_addr[k]] = d_wd[k];
    else if (!g && c_req[k] && c_we[k]) mram[k][c_addr[k]] = c_wd[k];
  endtask

  task automatic compare(input int k);
    bit g;
    g = grant_m(k);
    chk("ack",       k, o_ack[k],   m_ack[k]);
    chk("stall",     k, o_stall[k], g && c_req[k]);
    chk("mem_addr",  k, o_maddr[k], g ? d_addr[k] : c_addr[k]);
    chk("mem_we",    k, o_mwe[k],   g ? d_we[k] : (c_req[k] & c_we[k]));
    chk("mem_wdata", k, o_mwd[k],   g ? d_wd[k] : c_wd[k]);
    chk("cpu_rdata", k, o_crd[k],   m_cpu[k]);
    chk("dbg_rdata", k, o_drd[k],   m_dbg[k]);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) model_step(k);
      @(negedge clk);
      for (int k = 0; k < 2; k++) compare(k);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_set(input int k, input logic rq, input logic we, input logic [7:0] a, input logic [7:0] d);
    c_req[k] = rq; c_we[k] = we; c_addr[k] = a; c_wd[k] = d;
  endtask

  task automatic dbg_set(input int k, input logic rq, input logic we, input logic [7:0] a, input logic [7:0] d);
    d_req[k] = rq; d_we[k] = we; d_addr[k] = a; d_wd[k] = d;
  endtask

  logic [7:0] b2b_exp [4];

  initial begin
    b2b_exp = '{8'h31, 8'h34, 8'h37, 8'h3A};
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) ram[k][i] = 8'(i * 3 + 1);
      ram[k][8'h02] = 8'h00; ram[k][8'h05] = 8'h3C;
      ram[k][8'h07] = 8'hA5; ram[k][8'h08] = 8'h5A;
      for (int i = 0; i < 256; i++) mram[k][i] = ram[k][i];
      rd[k] = 8'h00;
      cpu_set(k, 0, 0, 8'h00, 8'h00);
      dbg_set(k, 0, 0, 8'h00, 8'h00);
    end
    i_rst = 1'b1;
    repeat (3) step();
    i_rst = 1'b0;

    // Idle debug read of 0x05
    dbg_set(0, 1, 0, 8'h05, 8'h00); #1;
    chk("idle_mem_addr", 0, o_maddr[0], 8'h05);
    chk("idle_stall", 0, o_stall[0], 0);
    chk("idle_ack_early", 0, o_ack[0], 0);
    step();
    chk("idle_ack", 0, o_ack[0], 1);
    chk("idle_stall_ack", 0, o_stall[0], 0);
    dbg_set(0, 0, 0, 8'h00, 8'h00);
    step();
    chk("idle_dbg_rdata", 0, o_drd[0], 8'h3C);
    chk("idle_ack_gone", 0, o_ack[0], 0);
    $display("txn idle debug read addr=05 data=%h", o_drd[0]);

    // Reset in the middle of a pending debug read (wait counter at 2)
    cpu_set(0, 1, 0, 8'h00, 8'h00); dbg_set(0, 1, 0, 8'h08, 8'h00);
    step();
    step(); i_rst = 1'b1; #1;
    chk("rst_ack0", 0, o_ack[0], 0);
    step();
    chk("rst_ack1", 0, o_ack[0], 0);
    chk("rst_dbg_rdata", 0, o_drd[0], 8'h00);
    step(); i_rst = 1'b0;
    cpu_set(0, 0, 0, 8'h00, 8'h00); dbg_set(0, 0, 0, 8'h00, 8'h00); #1;
    chk("rst_ack2", 0, o_ack[0], 0);
    chk("rst_wait_cnt", 0, g_dut[0].u_dut.wait_cnt_reg, 0);
    chk("rst_dbg_rdata2", 0, o_drd[0], 8'h00);
    chk("rst_cpu_rdata", 0, o_crd[0], 8'h00);
    $display("txn reset during debug read dropped, dbg_rdata=%h", o_drd[0]);

    // CPU priority with STARVE=3
    step();
    cpu_set(0, 1, 1, 8'h02, 8'h11); dbg_set(0, 1, 1, 8'h02, 8'h99);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("prio_cpu_stall", 0, o_stall[0], 0);
      chk("prio_cpu_wdata", 0, o_mwd[0], 8'h11);
      chk("prio_cpu_we", 0, o_mwe[0], 1);
      step();
    end
    chk("prio_forced_stall", 0, o_stall[0], 1);
    chk("prio_dbg_wdata", 0, o_mwd[0], 8'h99);
    chk("prio_dbg_we", 0, o_mwe[0], 1);
    step();
    chk("prio_ack", 0, o_ack[0], 1);
    chk("prio_stall_ack", 0, o_stall[0], 0);
    chk("prio_ram_dbg", 0, ram[0][8'h02], 8'h99);
    chk("prio_cpu_retry", 0, o_mwd[0], 8'h11);
    dbg_set(0, 0, 0, 8'h00, 8'h00);
    step();
    cpu_set(0, 0, 0, 8'h00, 8'h00);
    chk("prio_ram_final", 0, ram[0][8'h02], 8'h11);
    $display("txn priority debug write 02 then cpu write, ram[02]=%h", ram[0][8'h02]);

    // CPU read data held across a forced debug read
    step();
    cpu_set(0, 1, 0, 8'h00, 8'h00); dbg_set(0, 1, 0, 8'h08, 8'h00);
    step();
    step(); cpu_set(0, 1, 0, 8'h07, 8'h00); #1;
    chk("hold_no_stall", 0, o_stall[0], 0);
    step(); cpu_set(0, 1, 0, 8'h09, 8'h00); #1;
    chk("hold_stall", 0, o_stall[0], 1);
    chk("hold_cpu_n1", 0, o_crd[0], 8'hA5);
    chk("hold_mem_addr", 0, o_maddr[0], 8'h08);
    step(); dbg_set(0, 0, 0, 8'h00, 8'h00); #1;
    chk("hold_ack", 0, o_ack[0], 1);
    chk("hold_cpu_n2", 0, o_crd[0], 8'hA5);
    step(); cpu_set(0, 0, 0, 8'h00, 8'h00); #1;
    chk("hold_dbg_rdata", 0, o_drd[0], 8'h5A);
    chk("hold_cpu_next", 0, o_crd[0], 8'h1C);
    $display("txn read hold cpu=A5 dbg addr=08 data=%h", o_drd[0]);

    // Back-to-back debug reads with dbg_req held high
    for (int i = 0; i < 4; i++) begin
      step();
      dbg_set(0, 1, 0, 8'(8'h10 + i), 8'h00); #1;
      chk("b2b_ack_low", 0, o_ack[0], 0);
      if (i > 0) chk("b2b_rdata", 0, o_drd[0], b2b_exp[i-1]);
      step();
      chk("b2b_ack", 0, o_ack[0], 1);
      $display("txn b2b debug read addr=%h acked", 8'(8'h10 + i));
    end
    step(); dbg_set(0, 0, 0, 8'h00, 8'h00); #1;
    chk("b2b_rdata_last", 0, o_drd[0], 8'h3A);

    // STARVE=0 instance: immediate grant on every collision
    cpu_set(1, 1, 0, 8'h07, 8'h00); dbg_set(1, 1, 0, 8'h05, 8'h00); #1;
    chk("s0_stall", 1, o_stall[1], 1);
    chk("s0_mem_addr", 1, o_maddr[1], 8'h05);
    step();
    chk("s0_ack", 1, o_ack[1], 1);
    chk("s0_no_grant_ack", 1, o_stall[1], 0);
    chk("s0_cpu_owns", 1, o_maddr[1], 8'h07);
    step();
    chk("s0_stall2", 1, o_stall[1], 1);
    chk("s0_ack_low", 1, o_ack[1], 0);
    step(); dbg_set(1, 0, 0, 8'h00, 8'h00); #1;
    chk("s0_ack2", 1, o_ack[1], 1);
    chk("s0_stall_ack2", 1, o_stall[1], 0);
    step(); cpu_set(1, 0, 0, 8'h00, 8'h00); #1;
    chk("s0_cpu_rdata", 1, o_crd[1], 8'hA5);
    chk("s0_dbg_rdata", 1, o_drd[1], 8'h3C);
    $display("txn starve0 collisions cpu=%h dbg=%h", o_crd[1], o_drd[1]);

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t got=running want=finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
